alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_seq_muldiv.sv | 95 +++++++++
 rtl/alu_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   - opcode constants OP_ADD..OP_XOR (3-bit sel encoding)
//   - FSM state type for the top-level controller
//   - helper to classify opcodes that need the iterative engine
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative multiply / divide engine, one bit per clock.
//   clk, rst   : clock, async active-high reset
//   a_i, b_i   : operands, captured on the go_i edge
//   div_i      : 0 = shift-add multiply, 1 = restoring divide (captured with go_i)
//   go_i       : start a new WIDTH-cycle operation
//   lo_o, hi_o : value of the iteration being applied on the current edge
//                (product low/high, or quotient/remainder on the final one)
//   finish_o   : high during the cycle whose rising edge performs the last
//                iteration; lo_o/hi_o then carry the final result
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             div_i,
    input  logic             go_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             finish_o
);

    localparam int CW = $clog2(WIDTH + 1);

    // mul: hi_q:lo_q is the partial product, lo_q also holds the unused multiplier bits
    // div: hi_q is the partial remainder, lo_q shifts dividend out / quotient in
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] b_q;
    logic             div_q;
    logic             run_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] mul_shift;
    logic [WIDTH:0]   div_part;
    logic [WIDTH:0]   div_trial;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        mul_shift = {mul_sum, lo_q} >> 1;

        // partial remainder stays below b, so a successful trial always fits in WIDTH bits
        div_part  = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_part - {1'b0, b_q};

        lo_d = lo_q;
        hi_d = hi_q;
        if (div_q) begin
            if (!div_trial[WIDTH]) begin
                hi_d = div_trial[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_part[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_shift[2*WIDTH-1:WIDTH];
            lo_d = mul_shift[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q  <= '0;
            hi_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (go_i) begin
            lo_q  <= a_i;
            hi_q  <= '0;
            b_q   <= b_i;
            div_q <= div_i;
            run_q <= 1'b1;
            cnt_q <= CW'(WIDTH);
        end else if (run_q) begin
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign lo_o     = lo_d;
    assign hi_o     = hi_d;
    assign finish_o = run_q && (cnt_q == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic ops, WIDTH-cycle mul/div.
//   clk, rst  : clock, async active-high reset
//   a, b, sel : operands and opcode, sampled on the accepting edge
//   start     : request, accepted only in IDLE
//   busy      : multi-cycle op in progress
//   done      : one-cycle pulse with each new result
//   res/resHi : result low word / product high half or remainder
//   zeroFlag, carryFlag, divByZero : result flags, held with the result
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] resHi,
    output logic             zeroFlag,
    output logic             carryFlag,
    output logic             divByZero
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] reshi_q, reshi_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             is_div_q, is_div_d;

    logic             go;
    logic [WIDTH-1:0] eng_lo;
    logic [WIDTH-1:0] eng_hi;
    logic             eng_finish;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .a_i      (a),
        .b_i      (b),
        .div_i    (sel == OP_DIV),
        .go_i     (go),
        .lo_o     (eng_lo),
        .hi_o     (eng_hi),
        .finish_o (eng_finish)
    );

    always_comb begin
        add_w = {1'b0, a} + {1'b0, b};
        sub_w = {1'b0, a} - {1'b0, b};

        state_d  = state_q;
        res_d    = res_q;
        reshi_d  = reshi_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        dbz_d    = dbz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        is_div_d = is_div_q;
        go       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_iterative(sel) && !(sel == OP_DIV && b == '0)) begin
                        go       = 1'b1;
                        busy_d   = 1'b1;
                        is_div_d = (sel == OP_DIV);
                        state_d  = ST_CALC;
                    end else begin
                        reshi_d = '0;
                        carry_d = 1'b0;
                        dbz_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                        case (sel)
                            OP_ADD: begin
                                res_d   = add_w[WIDTH-1:0];
                                carry_d = add_w[WIDTH];
                            end
                            OP_SUB: begin
                                res_d   = sub_w[WIDTH-1:0];
                                carry_d = sub_w[WIDTH];
                            end
                            OP_DIV: begin
                                // only reached with b == 0
                                res_d   = '1;
                                reshi_d = a;
                                dbz_d   = 1'b1;
                            end
                            OP_AND:  res_d = a & b;
                            OP_OR:   res_d = a | b;
                            OP_NAND: res_d = ~(a & b);
                            OP_XOR:  res_d = a ^ b;
                            default: res_d = '0;
                        endcase
                    end
                end
            end
            ST_CALC: begin
                if (eng_finish) begin
                    res_d   = eng_lo;
                    reshi_d = eng_hi;
                    carry_d = is_div_q ? 1'b0 : (eng_hi != '0);
                    dbz_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // zero flag tracks whatever result is being written this edge
        if (done_d) begin
            zero_d = (res_d == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            res_q    <= '0;
            reshi_q  <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            reshi_q  <= reshi_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            is_div_q <= is_div_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign res       = res_q;
    assign resHi     = reshi_q;
    assign zeroFlag  = zero_q;
    assign carryFlag = carry_q;
    assign divByZero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] res;
    logic [W-1:0] resHi;
    logic         zeroFlag;
    logic         carryFlag;
    logic         divByZero;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .res       (res),
        .resHi     (resHi),
        .zeroFlag  (zeroFlag),
        .carryFlag (carryFlag),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive a request just after an edge; returns just after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
        sel   = op;
        a     = va;
        b     = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // bounded wait for done; cyc = edges after the accepting edge, -1 on timeout
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            tick();
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    initial begin
        int           cyc;
        int           bcnt;
        int           dcnt;
        int           done_at;
        logic [W-1:0] res_cap;
        logic [W-1:0] hi_cap;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; sel = OP_ADD;
        repeat (2) tick();
        check("rst_res",   res, 0);
        check("rst_resHi", resHi, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_flags", {zeroFlag, carryFlag, divByZero}, 0);
        rst = 1'b0;
        tick();

        issue(OP_ADD, 8'd4, 8'd100);
        check("add1_done",  done, 1);
        check("add1_res",   res, 104);
        check("add1_carry", carryFlag, 0);
        check("add1_zero",  zeroFlag, 0);
        tick();
        check("add1_pulse", done, 0);
        check("add1_hold",  res, 104);

        issue(OP_ADD, 8'd200, 8'd100);
        check("add2_res",   res, 44);
        check("add2_carry", carryFlag, 1);
        tick();

        issue(OP_SUB, 8'd10, 8'd10);
        check("sub1_res",   res, 0);
        check("sub1_zero",  zeroFlag, 1);
        check("sub1_carry", carryFlag, 0);
        tick();

        issue(OP_SUB, 8'd3, 8'd5);
        check("sub2_res",   res, 254);
        check("sub2_carry", carryFlag, 1);
        check("sub2_zero",  zeroFlag, 0);
        tick();

        issue(OP_XOR, 8'hA5, 8'h0F);
        check("xor_res", res, 8'hAA);
        tick();

        issue(OP_OR, 8'h50, 8'h0A);
        check("or_res", res, 8'h5A);
        tick();

        issue(OP_MUL, 8'd20, 8'd10);
        check("mul1_busy",     busy, 1);
        check("mul1_nodone",   done, 0);
        check("mul1_holdres",  res, 8'h5A);
        wait_done(cyc, bcnt);
        check("mul1_latency",  cyc, 8);
        check("mul1_busycyc",  bcnt, 8);
        check("mul1_res",      res, 200);
        check("mul1_resHi",    resHi, 0);
        check("mul1_carry",    carryFlag, 0);
        check("mul1_busyoff",  busy, 0);
        tick();

        issue(OP_MUL, 8'd255, 8'd255);
        wait_done(cyc, bcnt);
        check("mul2_latency", cyc, 8);
        check("mul2_res",     res, 8'h01);
        check("mul2_resHi",   resHi, 8'hFE);
        check("mul2_carry",   carryFlag, 1);
        tick();

        issue(OP_DIV, 8'd100, 8'd2);
        wait_done(cyc, bcnt);
        check("div1_latency", cyc, 8);
        check("div1_res",     res, 50);
        check("div1_resHi",   resHi, 0);
        check("div1_dbz",     divByZero, 0);
        tick();

        issue(OP_DIV, 8'd7, 8'd0);
        check("div0_done",  done, 1);
        check("div0_busy",  busy, 0);
        check("div0_res",   res, 255);
        check("div0_resHi", resHi, 7);
        check("div0_dbz",   divByZero, 1);
        check("div0_carry", carryFlag, 0);
        tick();

        issue(OP_DIV, 8'd100, 8'd7);
        wait_done(cyc, bcnt);
        check("div2_res",   res, 14);
        check("div2_resHi", resHi, 2);
        check("div2_dbz",   divByZero, 0);
        tick();

        // start pulsed mid-mul with new operands must be ignored
        issue(OP_MUL, 8'd20, 8'd10);
        tick();
        sel = OP_ADD; a = 8'd1; b = 8'd1; start = 1'b1;
        tick();
        start = 1'b0; sel = OP_DIV; a = 8'hFF; b = 8'hFF;
        dcnt = 0; done_at = 0; res_cap = '0; hi_cap = '0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin
                    done_at = i;
                    res_cap = res;
                    hi_cap  = resHi;
                end
            end
        end
        check("ign_pulses",  dcnt, 1);
        check("ign_latency", done_at, 6);
        check("ign_res",     res_cap, 200);
        check("ign_resHi",   hi_cap, 0);

        // reset during cycle 4 of a mul
        issue(OP_MUL, 8'd255, 8'd255);
        repeat (3) tick();
        check("abort_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_res",   res, 0);
        check("abort_resHi", resHi, 0);
        check("abort_busy",  busy, 0);
        check("abort_done",  done, 0);
        check("abort_flags", {zeroFlag, carryFlag, divByZero}, 0);
        tick();
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dcnt++;
        end
        check("abort_nodone", dcnt, 0);
        check("abort_idle_res", res, 0);

        issue(OP_NAND, 8'd122, 8'd100);
        check("nand_done", done, 1);
        check("nand_res",  res, 8'h9F);
        check("nand_hi",   resHi, 0);
        tick();
        check("nand_pulse", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
